ucie_ctl_adapter_sb_cfg_tx: RTL

- Adapter-side sideband config transmitter that drives the RDI lp_cfg channel into the PHY sideband message interface.
- Buffers whole sideband messages of MSG_W bits and serializes each one into MSG_W/NC beats on o_rdi_lp_cfg / o_rdi_lp_cfg_valid.
- Each message start is gated by PHY-returned credits on i_rdi_pl_cfg_crd.

---
 rtl/ucie_ctl_sb_pkg.sv | 17 +
 rtl/ucie_ctl_sb_msg_fifo.sv | 52 +++++
 rtl/ucie_ctl_adapter_sb_cfg_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared types and elaboration helpers for the adapter sideband config path.
package ucie_ctl_sb_pkg;

    typedef enum logic {SB_IDLE, SB_SEND} sb_tx_state_e;

    // Returns 0 when msg_w is not a whole number of beats, so the top can refuse to elaborate.
    function automatic int sb_beats(input int msg_w, input int nc);
        if (nc <= 0) return 0;
        if ((msg_w % nc) != 0) return 0;
        return msg_w / nc;
    endfunction

    function automatic int sb_crd_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_msg_fifo.sv
// Whole-message FIFO feeding the sideband serializer; push while full and pop while empty are ignored.
module ucie_ctl_sb_msg_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (cnt_q == FULL_CNT);
    assign o_empty = (cnt_q == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/ucie_ctl_adapter_sb_cfg_tx.sv
// Credit-gated serializer: buffers sideband messages and streams them LSB-first onto RDI lp_cfg.
//
// state   | meaning
// SB_IDLE | no beat on lp_cfg; waiting for a queued message and a credit
// SB_SEND | one beat per cycle of the current message; may chain the next without a bubble
module ucie_ctl_adapter_sb_cfg_tx
    import ucie_ctl_sb_pkg::*;
#(
    parameter int NC      = 32,
    parameter int MSG_W   = 128,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_msg_valid,
    input  logic [MSG_W-1:0]             i_msg_data,
    output logic                         o_msg_ready,
    output logic                         o_rdi_lp_cfg_valid,
    output logic [NC-1:0]                o_rdi_lp_cfg,
    input  logic                         i_rdi_pl_cfg_crd,
    output logic [$clog2(CREDITS+1)-1:0] o_credit_count,
    output logic                         o_busy,
    output logic                         o_crd_overflow
);
    localparam int BEATS = sb_beats(MSG_W, NC);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = sb_crd_w(CREDITS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] CRD_MAX   = CW'(CREDITS);

    if (BEATS < 1) begin : g_chk_msg_w
        $error("MSG_W must be a nonzero multiple of NC");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic             fifo_full;
    logic             fifo_empty;
    logic [MSG_W-1:0] fifo_head;

    sb_tx_state_e     state_q;
    logic [BW-1:0]    beat_q;
    logic [MSG_W-1:0] shift_q;
    logic             valid_q;
    logic [CW-1:0]    crd_q;
    logic [CW-1:0]    crd_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             last_beat;
    logic             launch;

    ucie_ctl_sb_msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_msg_valid),
        .i_data  (i_msg_data),
        .i_pop   (launch),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_head  (fifo_head)
    );

    assign last_beat = (state_q == SB_SEND) && (beat_q == LAST_BEAT);

    // A credit arriving on the last beat may fund the chained launch; from idle only the held count counts.
    always_comb begin
        launch = 1'b0;
        if (state_q == SB_IDLE) begin
            launch = !fifo_empty && (crd_q != '0);
        end else if (last_beat) begin
            launch = !fifo_empty && ((crd_q != '0) || i_rdi_pl_cfg_crd);
        end
    end

    always_comb begin
        crd_d = crd_q;
        ovf_d = ovf_q;
        if (launch && !i_rdi_pl_cfg_crd) begin
            crd_d = crd_q - CW'(1);
        end else if (!launch && i_rdi_pl_cfg_crd) begin
            if (crd_q == CRD_MAX) ovf_d = 1'b1;
            else                  crd_d = crd_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= SB_IDLE;
            beat_q  <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            crd_q   <= CRD_MAX;
            ovf_q   <= 1'b0;
        end else begin
            crd_q <= crd_d;
            ovf_q <= ovf_d;
            if (launch) begin
                state_q <= SB_SEND;
                beat_q  <= '0;
                shift_q <= fifo_head;
                valid_q <= 1'b1;
            end else if (state_q == SB_SEND) begin
                if (last_beat) begin
                    state_q <= SB_IDLE;
                    beat_q  <= '0;
                    shift_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    beat_q  <= beat_q + BW'(1);
                    shift_q <= shift_q >> NC;
                end
            end
        end
    end

    // shift_q is cleared whenever idle, so the beat bus is zero without extra gating.
    assign o_rdi_lp_cfg       = shift_q[NC-1:0];
    assign o_rdi_lp_cfg_valid = valid_q;
    assign o_credit_count     = crd_q;
    assign o_crd_overflow     = ovf_q;
    assign o_msg_ready        = !fifo_full;
    assign o_busy             = !fifo_empty || (state_q == SB_SEND);

endmodule
